bus_dma_arb: RTL and testbench

- Arbitrates the CPU core's external memory bus between the 65C02 core and NUM_REQ DMA requesters.
- Stalls the core through its rdy input, muxes address, write-data and write-enable onto the shared bus, and hands the bus back so the core's stalled read cycle repeats cleanly.
- Sits between the core top level and the memory/peripheral fabric.
- Memory is synchronous: read data is valid one cycle after the address.

---
 rtl/bus_dma_arb.sv | 168 ++++++++++++++++
 tb/tb_bus_dma_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_arb.sv
// bus_dma_arb: shares the 65C02 core's external memory bus with NUM_REQ DMA
// requesters. The core is stalled through rdy while a requester owns the bus.
// A single HANDBACK cycle then re-presents the core's stalled read address, so
// the repeated read returns fresh data before the core runs again.
// Optional feature macro: ARB_SYNC_ONLY_EN. When it is defined, grants are taken
// only on opcode-fetch (cpu_sync) cycles, so RMW and stack sequences stay whole.
module bus_dma_arb #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4,
  parameter int CPU_MIN   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             cpu_ab,
  input  logic [7:0]              cpu_do,
  input  logic                    cpu_we,
  input  logic                    cpu_sync,
  output logic                    rdy,
  output logic [15:0]             ab,
  output logic [7:0]              do_,
  output logic                    we,
  input  logic [NUM_REQ-1:0]      dma_req,
  input  logic [16*NUM_REQ-1:0]   dma_addr,
  input  logic [8*NUM_REQ-1:0]    dma_wdata,
  input  logic [NUM_REQ-1:0]      dma_we,
  output logic [NUM_REQ-1:0]      dma_ack,
  output logic [1:0]              owner,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_DMA,
    ST_HANDBACK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  burst_q, burst_d;
  logic [3:0]  holdoff_q, holdoff_d;

  // Requester signals widened to the full 4-entry index space of owner.
  logic [3:0]  req_pad;
  logic [3:0]  we_pad;
  logic [3:0]  ack_pad;
  logic [15:0] addr_arr  [4];
  logic [7:0]  wdata_arr [4];

  logic        grant_found;
  logic [1:0]  grant_idx;
  logic [1:0]  rr_cand;
  logic        grant_ok;

  assign req_pad = 4'(dma_req);
  assign we_pad  = 4'(dma_we);

  // Split the flat address/data buses into per-requester entries; unused slots read as zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_arr[i]  = 16'h0000;
      wdata_arr[i] = 8'h00;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = dma_addr[16*i +: 16];
      wdata_arr[i] = dma_wdata[8*i +: 8];
    end
  end

  // Round-robin search from the pointer; scanning backwards lets the nearest requester win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    rr_cand     = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_cand = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_pad[rr_cand]) begin
        grant_found = 1'b1;
        grant_idx   = rr_cand;
      end
    end
  end

  // A core write is never stalled; the sync-only build also waits for an opcode fetch.
`ifdef ARB_SYNC_ONLY_EN
  assign grant_ok = grant_found && !cpu_we && cpu_sync;
`else
  logic unused_sync;
  assign unused_sync = cpu_sync;
  assign grant_ok    = grant_found && !cpu_we;
`endif

  // Next-state logic plus bus mux, rdy and ack generation for the current state.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner;
    rr_ptr_d  = rr_ptr_q;
    burst_d   = burst_q;
    holdoff_d = holdoff_q;
    ack_pad   = 4'b0000;
    rdy       = 1'b1;
    ab        = cpu_ab;
    do_       = cpu_do;
    we        = cpu_we;

    case (state_q)
      ST_CPU: begin
        if (holdoff_q != 4'd0) begin
          holdoff_d = holdoff_q - 4'd1;
        end else if (grant_ok) begin
          state_d  = ST_DMA;
          owner_d  = grant_idx;
          rr_ptr_d = 2'((int'(grant_idx) + 1) % NUM_REQ);
          burst_d  = 4'd0;
        end
      end

      ST_DMA: begin
        rdy = 1'b0;
        ab  = addr_arr[owner];
        do_ = wdata_arr[owner];
        // A write strobe only reaches the bus in a cycle that is actually acked.
        we  = we_pad[owner] & req_pad[owner];
        if (req_pad[owner]) begin
          ack_pad[owner] = 1'b1;
          burst_d        = burst_q + 4'd1;
          if (burst_q == 4'(MAX_BURST - 1)) begin
            state_d = ST_HANDBACK;
          end
        end else begin
          state_d = ST_HANDBACK;
        end
      end

      ST_HANDBACK: begin
        rdy       = 1'b0;
        we        = 1'b0;
        state_d   = ST_CPU;
        holdoff_d = 4'(CPU_MIN);
      end

      default: begin
        state_d = ST_CPU;
      end
    endcase
  end

  assign dma_ack = ack_pad[NUM_REQ-1:0];
  assign busy    = (state_q != ST_CPU);

  // State, owner, round-robin pointer and counters; reset abandons any burst without an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CPU;
      owner     <= 2'd0;
      rr_ptr_q  <= 2'd0;
      burst_q   <= 4'd0;
      holdoff_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      owner     <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      burst_q   <= burst_d;
      holdoff_q <= holdoff_d;
    end
  end

endmodule

// File: tb/tb_bus_dma_arb.sv
// tb_bus_dma_arb: directed vector table plus hand-written multi-cycle sequences
// for bus_dma_arb with NUM_REQ=2, MAX_BURST=4, CPU_MIN=2.
module tb_bus_dma_arb;

  localparam int NUM_REQ   = 2;
  localparam int MAX_BURST = 4;
  localparam int CPU_MIN   = 2;

  logic                  clk;
  logic                  reset_n;
  logic [15:0]           cpu_ab;
  logic [7:0]            cpu_do;
  logic                  cpu_we;
  logic                  cpu_sync;
  logic                  rdy;
  logic [15:0]           ab;
  logic [7:0]            do_;
  logic                  we;
  logic [NUM_REQ-1:0]    dma_req;
  logic [16*NUM_REQ-1:0] dma_addr;
  logic [8*NUM_REQ-1:0]  dma_wdata;
  logic [NUM_REQ-1:0]    dma_we;
  logic [NUM_REQ-1:0]    dma_ack;
  logic [1:0]            owner;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cwe;
    logic        csync;
    logic [1:0]  req;
    logic [1:0]  dwe;
    logic        exp_rdy;
    logic [1:0]  exp_ack;
    logic        exp_busy;
    logic [1:0]  exp_owner;
    logic [15:0] exp_ab;
    logic [7:0]  exp_do;
    logic        exp_we;
  } vec_t;

  vec_t vecs[$];

  bus_dma_arb #(
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .CPU_MIN  (CPU_MIN)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_ab   (cpu_ab),
    .cpu_do   (cpu_do),
    .cpu_we   (cpu_we),
    .cpu_sync (cpu_sync),
    .rdy      (rdy),
    .ab       (ab),
    .do_      (do_),
    .we       (we),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_we   (dma_we),
    .dma_ack  (dma_ack),
    .owner    (owner),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s #%0d: got %0h expected %0h", name, idx, actual, expected);
    end
  endtask

  task automatic addVec(input logic cwe, input logic [1:0] req, input logic [1:0] dwe,
                        input logic e_rdy, input logic [1:0] e_ack, input logic e_busy,
                        input logic [1:0] e_owner, input logic [15:0] e_ab,
                        input logic [7:0] e_do, input logic e_we);
    vec_t v;
    v.cwe = cwe;       v.csync = 1'b1;     v.req = req;         v.dwe = dwe;
    v.exp_rdy = e_rdy; v.exp_ack = e_ack;  v.exp_busy = e_busy; v.exp_owner = e_owner;
    v.exp_ab = e_ab;   v.exp_do = e_do;    v.exp_we = e_we;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    cpu_we   = v.cwe;
    cpu_sync = v.csync;
    dma_req  = v.req;
    dma_we   = v.dwe;
  endtask

  task automatic checkVector(input vec_t v, input int i);
    checkOutput("vec_rdy",   i, 32'(rdy),     32'(v.exp_rdy));
    checkOutput("vec_ack",   i, 32'(dma_ack), 32'(v.exp_ack));
    checkOutput("vec_busy",  i, 32'(busy),    32'(v.exp_busy));
    checkOutput("vec_owner", i, 32'(owner),   32'(v.exp_owner));
    checkOutput("vec_ab",    i, 32'(ab),      32'(v.exp_ab));
    checkOutput("vec_do",    i, 32'(do_),     32'(v.exp_do));
    checkOutput("vec_we",    i, 32'(we),      32'(v.exp_we));
  endtask

  task automatic doReset();
    cpu_we   = 1'b0;
    cpu_sync = 1'b1;
    dma_req  = '0;
    dma_we   = '0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int waited;
    int pulses;
    cpu_ab    = 16'h0200;
    cpu_do    = 8'h55;
    cpu_we    = 1'b0;
    cpu_sync  = 1'b1;
    dma_req   = '0;
    dma_we    = '0;
    dma_addr  = {16'h2000, 16'h1000};
    dma_wdata = {8'hB1, 8'hA0};
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;

    // Reset values while reset_n is held low.
    @(negedge clk);
    checkOutput("reset_rdy",   0, 32'(rdy),     32'd1);
    checkOutput("reset_ack",   0, 32'(dma_ack), 32'd0);
    checkOutput("reset_busy",  0, 32'(busy),    32'd0);
    checkOutput("reset_owner", 0, 32'(owner),   32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // cwe, req, dwe | rdy, ack, busy, owner, ab, do, we
    addVec(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v0 idle
    addVec(0, 2'b01, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v1 grant edge
    addVec(0, 2'b01, 2'b00, 0, 2'b01, 1, 0, 16'h1000, 8'hA0, 0); // v2 ack0
    addVec(0, 2'b01, 2'b00, 0, 2'b01, 1, 0, 16'h1000, 8'hA0, 0); // v3 ack0
    addVec(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 16'h1000, 8'hA0, 0); // v4 req dropped
    addVec(1, 2'b00, 2'b00, 0, 2'b00, 1, 0, 16'h0200, 8'h55, 0); // v5 handback, we forced 0
    addVec(0, 2'b01, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v6 holdoff 2
    addVec(0, 2'b01, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v7 holdoff 1
    addVec(0, 2'b01, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v8 grant edge
    addVec(0, 2'b01, 2'b00, 0, 2'b01, 1, 0, 16'h1000, 8'hA0, 0); // v9
    addVec(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 16'h1000, 8'hA0, 0); // v10
    addVec(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 16'h0200, 8'h55, 0); // v11 handback
    for (int i = 0; i < 3; i++)
      addVec(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v12-14
    addVec(0, 2'b10, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v15 grant to 1
    for (int i = 0; i < MAX_BURST; i++)
      addVec(0, 2'b10, 2'b00, 0, 2'b10, 1, 1, 16'h2000, 8'hB1, 0); // v16-19 burst
    addVec(0, 2'b10, 2'b00, 0, 2'b00, 1, 1, 16'h0200, 8'h55, 0); // v20 handback
    for (int i = 0; i < CPU_MIN + 1; i++)
      addVec(0, 2'b10, 2'b00, 1, 2'b00, 0, 1, 16'h0200, 8'h55, 0); // v21-23
    for (int i = 0; i < MAX_BURST; i++)
      addVec(0, 2'b10, 2'b00, 0, 2'b10, 1, 1, 16'h2000, 8'hB1, 0); // v24-27 burst
    addVec(0, 2'b10, 2'b00, 0, 2'b00, 1, 1, 16'h0200, 8'h55, 0); // v28 handback
    for (int i = 0; i < 3; i++)
      addVec(0, 2'b00, 2'b00, 1, 2'b00, 0, 1, 16'h0200, 8'h55, 0); // v29-31
    for (int i = 0; i < 3; i++)
      addVec(1, 2'b01, 2'b00, 1, 2'b00, 0, 1, 16'h0200, 8'h55, 1); // v32-34 core writes
    addVec(0, 2'b01, 2'b00, 1, 2'b00, 0, 1, 16'h0200, 8'h55, 0); // v35 grant on read
    addVec(0, 2'b01, 2'b01, 0, 2'b01, 1, 0, 16'h1000, 8'hA0, 1); // v36 dma write
    addVec(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 16'h1000, 8'hA0, 0); // v37
    addVec(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 16'h0200, 8'h55, 0); // v38 handback
    addVec(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v39
    addVec(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 16'h0200, 8'h55, 0); // v40

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(vecs[i], i);
      @(posedge clk);
      #1;
    end

    // Reset in the second DMA cycle, then the pointer must restart at 0.
    doReset();
    dma_req = 2'b01;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midrst_first_ack", 0, 32'(dma_ack), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_rdy",   0, 32'(rdy),     32'd1);
    checkOutput("midrst_ack",   0, 32'(dma_ack), 32'd0);
    checkOutput("midrst_busy",  0, 32'(busy),    32'd0);
    checkOutput("midrst_owner", 0, 32'(owner),   32'd0);
    dma_req = 2'b11;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cpu_busy", 0, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("midrst_regrant_owner", 0, 32'(owner),   32'd0);
    checkOutput("midrst_regrant_ack",   0, 32'(dma_ack), 32'd1);

    // Both requests held from reset: bursts alternate 0,1,0,1, each MAX_BURST long.
    doReset();
    dma_req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      waited = 0;
      @(negedge clk);
      while (dma_ack == '0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("rr_grant_seen", b, 32'(dma_ack != '0), 32'd1);
      checkOutput("rr_owner",      b, 32'(owner),         32'(b % 2));
      pulses = 0;
      while (dma_ack != '0 && pulses < 20) begin
        pulses++;
        @(negedge clk);
      end
      checkOutput("rr_burst_len",  b, 32'(pulses),        32'(MAX_BURST));
    end

    // Request raised during a non-sync core read.
    @(posedge clk); #1;
    doReset();
    cpu_sync = 1'b0;
    dma_req  = 2'b01;
    @(negedge clk);
    checkOutput("sync_first_busy", 0, 32'(busy), 32'd0);
    @(posedge clk); #1;
`ifdef ARB_SYNC_ONLY_EN
    @(negedge clk);
    checkOutput("sync_hold_busy", 0, 32'(busy), 32'd0);
    @(posedge clk); #1;
    cpu_sync = 1'b1;
    @(negedge clk);
    checkOutput("sync_fetch_busy", 0, 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("sync_grant_busy", 0, 32'(busy),    32'd1);
    checkOutput("sync_grant_ack",  0, 32'(dma_ack), 32'd1);
`else
    @(negedge clk);
    checkOutput("nosync_grant_busy", 0, 32'(busy),    32'd1);
    checkOutput("nosync_grant_ack",  0, 32'(dma_ack), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
